i2s_rx: RTL

// - Receive side of the board's I2S audio link: deserialises an external I2S stream (BCK/LRCK/DATA

---
 rtl/i2s_rx.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
// I2S slave receiver: deserialises BCK/LRCK/DATA into parallel left/right PCM pairs in clk_sys.
// Define I2S_RX_LJ_EN for left-justified framing; default build is Philips I2S (1-BCK data delay).
`timescale 1ns/1ps
module i2s_rx #(
  parameter int AUDIO_DW    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                i2s_bck,
  input  logic                i2s_lrck,
  input  logic                i2s_data,
  output logic [AUDIO_DW-1:0] left,
  output logic [AUDIO_DW-1:0] right,
  output logic                sample_valid,
  output logic                locked
);
  localparam int CNT_W = $clog2(AUDIO_DW + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {HUNT = 2'd0, ALIGN = 2'd1, RUN = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] bck_sync_q, bck_sync_d;
  logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   bck_hist_q, bck_hist_d;
  logic                   lrck_prev_q, lrck_prev_d;
  logic [AUDIO_DW-1:0]    shift_q, shift_d;
  logic [AUDIO_DW-1:0]    pending_q, pending_d;
  logic [AUDIO_DW-1:0]    word_q, word_d;
  logic [AUDIO_DW-1:0]    left_q, left_d;
  logic [AUDIO_DW-1:0]    right_q, right_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   emit_q, emit_d;
  logic                   valid_q, valid_d;
  logic                   s_bck, s_lrck, s_data;
  logic                   bck_rise, lr_edge, wd_expire;
  logic [AUDIO_DW-1:0]    captured, completed;

  always_comb begin
    bck_sync_d  = {bck_sync_q[SYNC_STAGES-2:0], i2s_bck};
    lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], i2s_lrck};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], i2s_data};
    bck_hist_d  = bck_sync_q[SYNC_STAGES-1];
  end

  // Synchronisers are left unreset so a reset while BCK is high cannot fake a BCK rise.
  always_ff @(posedge clk_sys) begin
    bck_sync_q  <= bck_sync_d;
    lrck_sync_q <= lrck_sync_d;
    data_sync_q <= data_sync_d;
    bck_hist_q  <= bck_hist_d;
  end

  assign s_bck     = bck_sync_q[SYNC_STAGES-1];
  assign s_lrck    = lrck_sync_q[SYNC_STAGES-1];
  assign s_data    = data_sync_q[SYNC_STAGES-1];
  assign bck_rise  = s_bck & ~bck_hist_q;
  assign lr_edge   = s_lrck ^ lrck_prev_q;
  assign wd_expire = ~bck_rise & (wd_q == WD_W'(TIMEOUT - 1));

  // Bit k of a word lands at AUDIO_DW-1-k; a saturated count matches no position (truncate).
  generate
    for (genvar gi = 0; gi < AUDIO_DW; gi++) begin : g_cap
      assign captured[gi] = (cnt_q == CNT_W'(AUDIO_DW - 1 - gi)) ? s_data : shift_q[gi];
    end
  endgenerate

  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= HUNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (wd_expire) begin
      state_d = HUNT;
    end else if (bck_rise && lr_edge) begin
      case (state_q)
        HUNT:    state_d = ALIGN;
        ALIGN:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    locked = (state_q == RUN);
  end

  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    lrck_prev_d = lrck_prev_q;
    pending_d   = pending_q;
    word_d      = word_q;
    emit_d      = 1'b0;
    wd_d        = wd_q + 1'b1;
    completed   = captured;
    if (wd_expire) begin
      shift_d   = '0;
      cnt_d     = '0;
      wd_d      = '0;
      pending_d = '0;
    end else if (bck_rise) begin
      wd_d        = '0;
      lrck_prev_d = s_lrck;
      if (state_q == HUNT) begin
        if (lr_edge) begin
`ifdef I2S_RX_LJ_EN
          shift_d = {s_data, {(AUDIO_DW-1){1'b0}}};
          cnt_d   = CNT_W'(1);
`else
          shift_d = '0;
          cnt_d   = '0;
`endif
        end
      end else if (lr_edge) begin
`ifdef I2S_RX_LJ_EN
        completed = shift_q;
        shift_d   = {s_data, {(AUDIO_DW-1){1'b0}}};
        cnt_d     = CNT_W'(1);
`else
        completed = captured;
        shift_d   = '0;
        cnt_d     = '0;
`endif
        if (lrck_prev_q) begin
          word_d = completed;
          emit_d = 1'b1;
        end else begin
          pending_d = completed;
        end
      end else begin
        shift_d = captured;
        cnt_d   = (cnt_q == CNT_W'(AUDIO_DW)) ? cnt_q : cnt_q + 1'b1;
      end
    end
  end

  // The pair is presented one cycle after the right word completes.
  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    valid_d = emit_q;
    if (emit_q) begin
      left_d  = pending_q;
      right_d = word_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lrck_prev_q <= 1'b0;
      shift_q     <= '0;
      pending_q   <= '0;
      word_q      <= '0;
      left_q      <= '0;
      right_q     <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
      emit_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      lrck_prev_q <= lrck_prev_d;
      shift_q     <= shift_d;
      pending_q   <= pending_d;
      word_q      <= word_d;
      left_q      <= left_d;
      right_q     <= right_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      emit_q      <= emit_d;
      valid_q     <= valid_d;
    end
  end

  assign left         = left_q;
  assign right        = right_q;
  assign sample_valid = valid_q;
endmodule
